mii_frame_sequencer: RTL and testbench

//  Frame-level controller for the 64-bit MII TX test datapath; sits where the random char generator sits.

---
 rtl/mii_seq_pkg.sv | 31 +++
 rtl/mii_payload_gen.sv | 86 ++++++++
 rtl/mii_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mii_frame_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_seq_pkg.sv
// rtl/mii_seq_pkg.sv - shared types and MII word constants for the frame sequencer
// Purpose: FSM state enum, MII control characters and the fixed 64-bit IDLE/START/TERM
//          words with their matching per-lane control masks.
// Ports:   none (package).
package mii_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_TERM  = 3'd3,
        ST_IFG   = 3'd4
    } state_e;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_PRE   = 8'h55;
    localparam logic [7:0] MII_SFD   = 8'hD5;

    // Lane 0 occupies bits [7:0], so the first character on the wire is the rightmost byte.
    localparam logic [63:0] IDLE_WORD  = {8{MII_IDLE}};
    localparam logic [63:0] TERM_WORD  = {{7{MII_IDLE}}, MII_TERM};
    localparam logic [63:0] START_WORD = {MII_SFD, {6{MII_PRE}}, MII_START};

    localparam logic [7:0] IDLE_CTRL  = 8'hFF;
    localparam logic [7:0] START_CTRL = 8'h01;
    localparam logic [7:0] DATA_CTRL  = 8'h00;
    localparam logic [7:0] TERM_CTRL  = 8'hFF;

endpackage

// File: rtl/mii_payload_gen.sv
// rtl/mii_payload_gen.sv - 64-bit payload word source (incrementing bytes or PRBS31)
// Purpose: presents the next payload word on o_word; i_advance consumes it.
//          Build option MII_SEQ_PRBS_PAYLOAD_EN selects a PRBS31 (x^31+x^28+1) source,
//          otherwise an incrementing byte pattern that restarts at 0x00 on i_restart.
// Ports:   clk, rst (async, active-high), i_restart (rewind pattern), i_advance (word used),
//          o_word[63:0] (current word, lane 0 = bits [7:0]).
module mii_payload_gen
    import mii_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_restart,
    input  logic        i_advance,
    output logic [63:0] o_word
);

`ifdef MII_SEQ_PRBS_PAYLOAD_EN

    localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

    logic [30:0] lfsr_q;
    logic [30:0] lfsr_d;
    logic [30:0] lfsr_run;
    logic [63:0] word;
    logic        fb;

    // The sequence runs continuously across frames; only reset reloads the seed.
    logic unused_restart;
    assign unused_restart = i_restart;

    // 64 serial steps unrolled; the first generated bit lands in bit 0 (oldest = lane 0).
    always_comb begin
        lfsr_run = lfsr_q;
        word     = '0;
        fb       = 1'b0;
        for (int i = 0; i < 64; i++) begin
            fb       = lfsr_run[30] ^ lfsr_run[27];
            word[i]  = fb;
            lfsr_run = {lfsr_run[29:0], fb};
        end
        lfsr_d = i_advance ? lfsr_run : lfsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_word = word;

`else

    logic [7:0] base_q;
    logic [7:0] base_d;

    always_comb begin
        base_d = base_q;
        if (i_restart) begin
            base_d = 8'h00;
        end else if (i_advance) begin
            base_d = base_q + 8'd8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= 8'h00;
        end else begin
            base_q <= base_d;
        end
    end

    // Lane j carries base + j; the 8-bit add wraps naturally at 256.
    always_comb begin
        o_word = '0;
        for (int j = 0; j < 8; j++) begin
            o_word[8*j +: 8] = base_q + 8'(j);
        end
    end

`endif

endmodule

// File: rtl/mii_frame_sequencer.sv
// rtl/mii_frame_sequencer.sv - frame-level MII TX word sequencer (top)
// Purpose: emits IDLE / START / DATA / TERM / IFG words forming well-formed 64-bit MII frames
//          with run-time payload length, IFG length and frame count.
//          Build option MII_SEQ_PRBS_PAYLOAD_EN switches the payload to PRBS31.
// Ports:   clk, rst (async, active-high), i_enable (run level), i_payload_words (0 -> 1),
//          i_ifg_words (0 -> 1), i_num_frames (0 = unlimited), o_data/o_ctrl (registered MII word),
//          o_busy (frame in progress), o_done (1-cycle pulse on final TERM), o_frame_cnt.
module mii_frame_sequencer
    import mii_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_W      = 16,
    parameter int IFG_W      = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [LEN_W-1:0]      i_payload_words,
    input  logic [IFG_W-1:0]      i_ifg_words,
    input  logic [CNT_W-1:0]      i_num_frames,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_frame_cnt
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("mii_frame_sequencer: only DATA_WIDTH=64 is supported");
    end

    // state_q always names the word currently on o_data: the next-state logic
    // also selects the word for that next state, so both register on the same edge.
    state_e            state_q,     state_d;
    logic [63:0]       data_q,      data_d;
    logic [7:0]        ctrl_q,      ctrl_d;
    logic              done_q,      done_d;
    logic              limit_q,     limit_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [IFG_W-1:0]  ifg_q,       ifg_d;
    logic [LEN_W-1:0]  word_cnt_q,  word_cnt_d;
    logic [IFG_W-1:0]  ifg_cnt_q,   ifg_cnt_d;

    logic              start_frame;
    logic              gen_restart;
    logic              gen_advance;
    logic [63:0]       gen_word;
    logic [CNT_W-1:0]  frame_cnt_inc;

    mii_payload_gen u_payload_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (gen_restart),
        .i_advance (gen_advance),
        .o_word    (gen_word)
    );

    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        data_d      = IDLE_WORD;
        ctrl_d      = IDLE_CTRL;
        done_d      = 1'b0;
        limit_d     = limit_q;
        frame_cnt_d = frame_cnt_q;
        len_d       = len_q;
        ifg_d       = ifg_q;
        word_cnt_d  = word_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        start_frame = 1'b0;
        gen_restart = 1'b0;
        gen_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_enable) begin
                    // Dropping enable ends the run: the next run counts from zero.
                    limit_d     = 1'b0;
                    frame_cnt_d = '0;
                end else if (!limit_q) begin
                    start_frame = 1'b1;
                end
            end

            ST_START: begin
                state_d     = ST_DATA;
                data_d      = gen_word;
                ctrl_d      = DATA_CTRL;
                gen_advance = 1'b1;
                word_cnt_d  = '0;
            end

            ST_DATA: begin
                if (word_cnt_q == len_q - LEN_W'(1)) begin
                    state_d     = ST_TERM;
                    data_d      = TERM_WORD;
                    ctrl_d      = TERM_CTRL;
                    frame_cnt_d = frame_cnt_inc;
                    // Exact-match compare: a limit lowered below the count never fires.
                    if ((i_num_frames != '0) && (frame_cnt_inc == i_num_frames)) begin
                        limit_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    word_cnt_d  = word_cnt_q + LEN_W'(1);
                    data_d      = gen_word;
                    ctrl_d      = DATA_CTRL;
                    gen_advance = 1'b1;
                end
            end

            ST_TERM: begin
                state_d   = ST_IFG;
                ifg_cnt_d = '0;
            end

            ST_IFG: begin
                if (ifg_cnt_q == ifg_q - IFG_W'(1)) begin
                    if (i_enable && !limit_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame configuration is captured here and held for the whole frame.
        if (start_frame) begin
            state_d     = ST_START;
            data_d      = START_WORD;
            ctrl_d      = START_CTRL;
            len_d       = (i_payload_words == '0) ? LEN_W'(1) : i_payload_words;
            ifg_d       = (i_ifg_words == '0) ? IFG_W'(1) : i_ifg_words;
            gen_restart = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= IDLE_WORD;
            ctrl_q      <= IDLE_CTRL;
            done_q      <= 1'b0;
            limit_q     <= 1'b0;
            frame_cnt_q <= '0;
            len_q       <= LEN_W'(1);
            ifg_q       <= IFG_W'(1);
            word_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            done_q      <= done_d;
            limit_q     <= limit_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            ifg_q       <= ifg_d;
            word_cnt_q  <= word_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_ctrl      = ctrl_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mii_frame_sequencer.sv
// tb/tb_mii_frame_sequencer.sv - directed self-checking bench for mii_frame_sequencer
module tb_mii_frame_sequencer;

    localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
    localparam logic [63:0] W_START = 64'hD5555555555555FB;
    localparam logic [63:0] W_TERM  = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_payload_words = 16'd1;
    logic [7:0]  i_ifg_words = 8'd1;
    logic [31:0] i_num_frames = 32'd0;
    logic [63:0] o_data;
    logic [7:0]  o_ctrl;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_frame_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mii_frame_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_payload_words (i_payload_words),
        .i_ifg_words     (i_ifg_words),
        .i_num_frames    (i_num_frames),
        .o_data          (o_data),
        .o_ctrl          (o_ctrl),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_frame_cnt     (o_frame_cnt)
    );

    // Incrementing payload reference: word k, lane j = (8k + j) mod 256.
    function automatic logic [63:0] inc_word(input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) begin
            w[8*j +: 8] = 8'((8 * k + j) % 256);
        end
        return w;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && o_busy; i++) step();
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: timed out waiting for busy low, busy=%b", name, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_enable = 1'b0;
        repeat (3) step();
        checks++;
        if (o_data !== W_IDLE || o_ctrl !== 8'hFF || o_busy !== 1'b0 || o_done !== 1'b0 || o_frame_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold: data=%h ctrl=%h busy=%b done=%b cnt=%0d required %h FF 0 0 0",
                     o_data, o_ctrl, o_busy, o_done, o_frame_cnt, W_IDLE);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_data !== W_IDLE || o_ctrl !== 8'hFF || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_release[%0d]: data=%h ctrl=%h busy=%b required %h FF 0", i, o_data, o_ctrl, o_busy, W_IDLE);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [63:0] ed [8];
        logic [7:0]  ec [8];
        logic        eb [8];
        logic        edn[8];
        logic [31:0] en_cnt[8];
        ed = '{W_START, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, W_TERM, W_IDLE, W_IDLE, W_IDLE, W_IDLE};
        ec = '{8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        eb = '{1, 1, 1, 1, 1, 1, 1, 0};
        edn = '{0, 0, 0, 1, 0, 0, 0, 0};
        en_cnt = '{0, 0, 0, 1, 1, 1, 1, 1};
        i_payload_words = 16'd2;
        i_ifg_words = 8'd3;
        i_num_frames = 32'd1;
        i_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
`ifndef MII_SEQ_PRBS_PAYLOAD_EN
            if (o_data !== ed[i] || o_ctrl !== ec[i]) begin
                failures++;
                $display("FAIL single_word[%0d]: data=%h ctrl=%h required %h %h", i, o_data, o_ctrl, ed[i], ec[i]);
            end
`else
            if (o_ctrl !== ec[i]) begin
                failures++;
                $display("FAIL single_ctrl[%0d]: ctrl=%h required %h", i, o_ctrl, ec[i]);
            end
`endif
            checks++;
            if (o_busy !== eb[i] || o_done !== edn[i] || o_frame_cnt !== en_cnt[i]) begin
                failures++;
                $display("FAIL single_status[%0d]: busy=%b done=%b cnt=%0d required %b %b %0d",
                         i, o_busy, o_done, o_frame_cnt, eb[i], edn[i], en_cnt[i]);
            end
        end
        // Limit reached: enable still high but no new frame may start.
        repeat (3) begin
            step();
            checks++;
            if (o_busy !== 1'b0 || o_data !== W_IDLE || o_frame_cnt !== 32'd1) begin
                failures++;
                $display("FAIL single_hold: busy=%b data=%h cnt=%0d required 0 %h 1", o_busy, o_data, o_frame_cnt, W_IDLE);
            end
        end
        i_enable = 1'b0;
        step();
        checks++;
        if (o_frame_cnt !== 32'd0) begin
            failures++;
            $display("FAIL single_clear: cnt=%0d required 0", o_frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        i_payload_words = 16'd0;
        i_ifg_words = 8'd0;
        i_num_frames = 32'd0;
        i_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            step();
            checks++;
            if (o_data !== W_START || o_ctrl !== 8'h01 || o_frame_cnt !== 32'(f)) begin
                failures++;
                $display("FAIL b2b_start[%0d]: data=%h ctrl=%h cnt=%0d required %h 01 %0d", f, o_data, o_ctrl, o_frame_cnt, W_START, f);
            end
            step();
            checks++;
`ifndef MII_SEQ_PRBS_PAYLOAD_EN
            if (o_data !== inc_word(0) || o_ctrl !== 8'h00) begin
                failures++;
                $display("FAIL b2b_data[%0d]: data=%h ctrl=%h required %h 00", f, o_data, o_ctrl, inc_word(0));
            end
`else
            if (o_ctrl !== 8'h00) begin
                failures++;
                $display("FAIL b2b_data[%0d]: ctrl=%h required 00", f, o_ctrl);
            end
`endif
            step();
            checks++;
            if (o_data !== W_TERM || o_frame_cnt !== 32'(f + 1) || o_done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_term[%0d]: data=%h cnt=%0d done=%b required %h %0d 0", f, o_data, o_frame_cnt, o_done, W_TERM, f + 1);
            end
            step();
            checks++;
            if (o_data !== W_IDLE || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ifg[%0d]: data=%h busy=%b required %h 1", f, o_data, o_busy, W_IDLE);
            end
            if (f == 2) i_enable = 1'b0;
        end
        step();
        checks++;
        if (o_busy !== 1'b0 || o_data !== W_IDLE || o_frame_cnt !== 32'd3) begin
            failures++;
            $display("FAIL b2b_stop: busy=%b data=%h cnt=%0d required 0 %h 3", o_busy, o_data, o_frame_cnt, W_IDLE);
        end
        step();
        checks++;
        if (o_frame_cnt !== 32'd0) begin
            failures++;
            $display("FAIL b2b_clear: cnt=%0d required 0", o_frame_cnt);
        end
    endtask

    task automatic test_disable_mid();
        i_payload_words = 16'd40;
        i_ifg_words = 8'd2;
        i_num_frames = 32'd0;
        i_enable = 1'b1;
        step();
        checks++;
        if (o_data !== W_START) begin
            failures++;
            $display("FAIL dis_start: data=%h required %h", o_data, W_START);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
`ifndef MII_SEQ_PRBS_PAYLOAD_EN
            if (o_data !== inc_word(k) || o_ctrl !== 8'h00) begin
                failures++;
                $display("FAIL dis_data[%0d]: data=%h ctrl=%h required %h 00", k, o_data, o_ctrl, inc_word(k));
            end
`else
            if (o_ctrl !== 8'h00) begin
                failures++;
                $display("FAIL dis_data[%0d]: ctrl=%h required 00", k, o_ctrl);
            end
`endif
            if (k == 10) i_enable = 1'b0;
        end
        step();
        checks++;
        if (o_data !== W_TERM || o_ctrl !== 8'hFF || o_frame_cnt !== 32'd1) begin
            failures++;
            $display("FAIL dis_term: data=%h ctrl=%h cnt=%0d required %h FF 1", o_data, o_ctrl, o_frame_cnt, W_TERM);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (o_data !== W_IDLE || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL dis_ifg[%0d]: data=%h busy=%b required %h 1", i, o_data, o_busy, W_IDLE);
            end
        end
        step();
        checks++;
        if (o_busy !== 1'b0 || o_data !== W_IDLE) begin
            failures++;
            $display("FAIL dis_idle: busy=%b data=%h required 0 %h", o_busy, o_data, W_IDLE);
        end
        step();
    endtask

    task automatic test_reset_mid();
        i_payload_words = 16'd8;
        i_ifg_words = 8'd1;
        i_num_frames = 32'd0;
        i_enable = 1'b1;
        // Frame 1 (1+8+1+1 words) then START and DATA words 0..5 of frame 2.
        repeat (11 + 7) step();
        checks++;
`ifndef MII_SEQ_PRBS_PAYLOAD_EN
        if (o_data !== inc_word(5) || o_frame_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rstmid_pre: data=%h cnt=%0d required %h 1", o_data, o_frame_cnt, inc_word(5));
        end
`else
        if (o_ctrl !== 8'h00 || o_frame_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rstmid_pre: ctrl=%h cnt=%0d required 00 1", o_ctrl, o_frame_cnt);
        end
`endif
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_data !== W_IDLE || o_ctrl !== 8'hFF || o_busy !== 1'b0 || o_frame_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_async: data=%h ctrl=%h busy=%b cnt=%0d required %h FF 0 0", o_data, o_ctrl, o_busy, o_frame_cnt, W_IDLE);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (o_data !== W_START) begin
            failures++;
            $display("FAIL rstmid_restart: data=%h required %h", o_data, W_START);
        end
        step();
`ifndef MII_SEQ_PRBS_PAYLOAD_EN
        checks++;
        if (o_data !== inc_word(0)) begin
            failures++;
            $display("FAIL rstmid_payload: data=%h required %h", o_data, inc_word(0));
        end
`endif
        i_enable = 1'b0;
        wait_idle("rstmid_drain");
        step();
    endtask

`ifdef MII_SEQ_PRBS_PAYLOAD_EN
    logic [30:0] prbs_m;

    task automatic prbs_ref(output logic [63:0] w);
        logic b;
        for (int i = 0; i < 64; i++) begin
            b = prbs_m[30] ^ prbs_m[27];
            w[i] = b;
            prbs_m = {prbs_m[29:0], b};
        end
    endtask

    task automatic run_prbs_frame(input string name);
        logic [63:0] w;
        i_enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            prbs_ref(w);
            checks++;
            if (o_data !== w || o_ctrl !== 8'h00) begin
                failures++;
                $display("FAIL %s[%0d]: data=%h ctrl=%h required %h 00", name, k, o_data, o_ctrl, w);
            end
        end
        wait_idle(name);
        i_enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_prbs();
        rst = 1'b1;
        i_enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        prbs_m = 31'h7FFFFFFF;
        i_payload_words = 16'd4;
        i_ifg_words = 8'd1;
        i_num_frames = 32'd1;
        run_prbs_frame("prbs_first");
        run_prbs_frame("prbs_continue");
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        prbs_m = 31'h7FFFFFFF;
        run_prbs_frame("prbs_reseed");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_disable_mid();
        test_reset_mid();
`ifdef MII_SEQ_PRBS_PAYLOAD_EN
        test_prbs();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
